branch_resolve: RTL and testbench

- Consumer side of the branch/jump condition-code interface.
- Takes a condition code from the decode-stage condition decoder, plus the operand values, branch PC and target.
- Evaluates taken/not-taken one cycle later and, when the branch is taken, holds a redirect request to fetch until fetch accepts it.
- Sits between decode/issue and the fetch PC mux; also keeps resolution statistics counters.

---
 rtl/branch_resolve.sv | 106 ++++++++++
 tb/tb_branch_resolve.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: evaluates decoded branch conditions one cycle after accept and
// holds a redirect to fetch until it is taken, counting resolved/taken branches.
module branch_resolve #(
   parameter int COND_W = 4,
   parameter int XLEN   = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [COND_W-1:0] in_cond,
   input  logic [XLEN-1:0]   in_a,
   input  logic [XLEN-1:0]   in_b,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_target,
   output logic              redir_valid,
   input  logic              redir_ready,
   output logic [XLEN-1:0]   redir_pc,
   output logic              flush,
   output logic [CNT_W-1:0]  taken_cnt,
   output logic [CNT_W-1:0]  resolve_cnt
);
   typedef enum logic [1:0] {IDLE, EVAL, WAIT} state_t;
   state_t state_q, state_d;
   logic [COND_W-1:0] cond_q, cond_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, tgt_q, tgt_d, pc_q, pc_d;
   logic [XLEN-1:0] redir_pc_q, redir_pc_d;
   logic redir_valid_q, redir_valid_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d, resolve_cnt_q, resolve_cnt_d;
   logic eq, lt, taken, is_br, accept;
   // Branch PC is kept only for debug visibility; nothing consumes it.
   logic unused_pc;
   assign unused_pc = ^pc_q;
   always_comb begin
      eq = a_q == b_q;
      lt = $signed(a_q) < $signed(b_q);
      taken = cond_q == COND_W'(1)  ? eq :
              cond_q == COND_W'(2)  ? !eq :
              cond_q == COND_W'(3)  ? lt :
              cond_q == COND_W'(4)  ? !lt :
              cond_q == COND_W'(5)  ? (lt || eq) :
              cond_q == COND_W'(6)  ? !(lt || eq) :
              cond_q == COND_W'(15);
      is_br = (cond_q >= COND_W'(1) && cond_q <= COND_W'(6)) || cond_q == COND_W'(15);
   end
   assign in_ready = state_q == IDLE || (state_q == EVAL && !taken);
   assign accept = in_valid && in_ready;
   assign redir_valid = redir_valid_q;
   assign redir_pc = redir_pc_q;
   assign flush = redir_valid_q && redir_ready;
   assign taken_cnt = taken_cnt_q;
   assign resolve_cnt = resolve_cnt_q;
   always_comb begin
      state_d = state_q;
      cond_d = accept ? in_cond : cond_q;
      a_d = accept ? in_a : a_q;
      b_d = accept ? in_b : b_q;
      tgt_d = accept ? in_target : tgt_q;
      pc_d = accept ? in_pc : pc_q;
      redir_valid_d = redir_valid_q;
      redir_pc_d = redir_pc_q;
      taken_cnt_d = taken_cnt_q;
      resolve_cnt_d = resolve_cnt_q;
      case (state_q)
         IDLE: state_d = accept ? EVAL : IDLE;
         EVAL: begin
            resolve_cnt_d = is_br ? resolve_cnt_q + CNT_W'(1) : resolve_cnt_q;
            taken_cnt_d = taken ? taken_cnt_q + CNT_W'(1) : taken_cnt_q;
            redir_valid_d = taken;
            redir_pc_d = taken ? tgt_q : redir_pc_q;
            state_d = taken ? WAIT : accept ? EVAL : IDLE;
         end
         WAIT: begin
            redir_valid_d = !redir_ready;
            state_d = redir_ready ? IDLE : WAIT;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cond_q <= '0;
         a_q <= '0;
         b_q <= '0;
         tgt_q <= '0;
         pc_q <= '0;
         redir_valid_q <= 1'b0;
         redir_pc_q <= '0;
         taken_cnt_q <= '0;
         resolve_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cond_q <= cond_d;
         a_q <= a_d;
         b_q <= b_d;
         tgt_q <= tgt_d;
         pc_q <= pc_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q <= redir_pc_d;
         taken_cnt_q <= taken_cnt_d;
         resolve_cnt_q <= resolve_cnt_d;
      end
   end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and random branches checked against a
// transaction-level model of the condition rules and counters.
module tb_branch_resolve;
   localparam int CW = 8;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, redir_ready = 1'b0;
   logic in_ready, redir_valid, flush;
   logic [3:0] in_cond = '0;
   logic [31:0] in_a = '0, in_b = '0, in_pc = '0, in_target = '0, redir_pc;
   logic [CW-1:0] taken_cnt, resolve_cnt;
   int checks = 0, failures = 0;
   logic [CW-1:0] m_tk = '0, m_res = '0;
   bit pend = 0;
   logic [3:0] p_c;
   logic [31:0] p_a, p_b;

   branch_resolve #(.COND_W(4), .XLEN(32), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_cond(in_cond), .in_a(in_a), .in_b(in_b), .in_pc(in_pc),
      .in_target(in_target), .redir_valid(redir_valid), .redir_ready(redir_ready),
      .redir_pc(redir_pc), .flush(flush), .taken_cnt(taken_cnt), .resolve_cnt(resolve_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_taken(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      case (c)
         4'd1: return sa == sb;
         4'd2: return sa != sb;
         4'd3: return sa < sb;
         4'd4: return sa >= sb;
         4'd5: return sa <= sb;
         4'd6: return sa > sb;
         4'd15: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic account(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      if ((c >= 4'd1 && c <= 4'd6) || c == 4'd15) m_res++;
      if (ref_taken(c, a, b)) m_tk++;
   endtask

   task automatic check_cnt();
      check("taken_cnt", 32'(taken_cnt), 32'(m_tk));
      check("resolve_cnt", 32'(resolve_cnt), 32'(m_res));
   endtask

   task automatic check_idle();
      check("idle_rv", 32'(redir_valid), 0);
      check("idle_rdy", 32'(in_ready), 1);
      check("idle_flush", 32'(flush), 0);
      check_cnt();
   endtask

   // Called at a falling edge with the unit able to accept (IDLE or not-taken EVAL).
   task automatic run(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] t, input int delay, input bit bb);
      bit tk;
      tk = ref_taken(c, a, b);
      in_valid = 1'b1;
      in_cond = c;
      in_a = a;
      in_b = b;
      in_pc = $urandom;
      in_target = t;
      check("acc_rdy", 32'(in_ready), 1);
      if (pend) begin
         check("bb_rv", 32'(redir_valid), 0);
         account(p_c, p_a, p_b);
         pend = 0;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("eval_rv", 32'(redir_valid), 0);
      check("eval_flush", 32'(flush), 0);
      check("eval_rdy", 32'(in_ready), 32'(!tk));
      if (tk) begin
         account(c, a, b);
         @(posedge clk);
         @(negedge clk);
         check("wait_rv", 32'(redir_valid), 1);
         check("wait_pc", redir_pc, t);
         check("wait_rdy", 32'(in_ready), 0);
         repeat (delay) begin
            in_valid = 1'b1;
            in_cond = 4'hF;
            in_target = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("hold_rv", 32'(redir_valid), 1);
            check("hold_pc", redir_pc, t);
            check("hold_rdy", 32'(in_ready), 0);
            check("hold_flush", 32'(flush), 0);
         end
         in_valid = 1'b0;
         redir_ready = 1'b1;
         #1;
         check("flush_hi", 32'(flush), 1);
         @(posedge clk);
         @(negedge clk);
         redir_ready = 1'b0;
         #1;
         check_idle();
      end else if (bb) begin
         pend = 1;
         p_c = c;
         p_a = a;
         p_b = b;
      end else begin
         account(c, a, b);
         @(posedge clk);
         @(negedge clk);
         check_idle();
      end
   endtask

   task automatic drain();
      if (pend) begin
         check("drain_rv", 32'(redir_valid), 0);
         account(p_c, p_a, p_b);
         pend = 0;
         @(posedge clk);
         @(negedge clk);
         check_idle();
      end
   endtask

   initial begin
      logic [31:0] va [3];
      logic [31:0] vb [3];
      logic [3:0] conds [3];
      bit exp_tab [3][3];
      logic [31:0] a, b;
      va = '{32'd3, 32'hFFFF_FFFE, 32'd1};
      vb = '{32'd3, 32'd1, 32'hFFFF_FFFE};
      conds = '{4'd4, 4'd5, 4'd6};
      exp_tab = '{'{1, 0, 1}, '{1, 1, 0}, '{0, 0, 1}};
      #1;
      check("rst_rdy", 32'(in_ready), 1);
      check("rst_rv", 32'(redir_valid), 0);
      check("rst_pc", redir_pc, 0);
      check("rst_flush", 32'(flush), 0);
      check_cnt();
      @(negedge clk);
      rst = 1'b0;
      run(4'd1, 32'h5, 32'h5, 32'h0000_1000, 0, 0);
      check("t1_taken", 32'(taken_cnt), 1);
      check("t1_res", 32'(resolve_cnt), 1);
      run(4'd2, 32'd7, 32'd7, 32'h0000_2000, 0, 1);
      run(4'd3, 32'hFFFF_FFFF, 32'd0, 32'h0000_3000, 0, 0);
      run(4'd15, 32'd0, 32'd9, 32'hDEAD_BEE0, 5, 0);
      run(4'd0, 32'd1, 32'd1, 32'h44, 0, 0);
      run(4'd10, 32'd1, 32'd1, 32'h48, 0, 0);
      check("t4_res", 32'(resolve_cnt), 4);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            check("sweep_ref", 32'(ref_taken(conds[i], va[j], vb[j])), 32'(exp_tab[i][j]));
            run(conds[i], va[j], vb[j], 32'h100 + 32'(i * 16 + j * 4), 0, 0);
         end
      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         b = $urandom_range(0, 2) == 0 ? a : $urandom_range(0, 1) ? $urandom : a + $urandom_range(0, 2) - 1;
         run(4'($urandom_range(0, 15)), a, b, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      drain();
      // Async reset while a redirect is pending.
      in_valid = 1'b1;
      in_cond = 4'hF;
      in_target = 32'hCAFE_0000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("prerst_rv", 32'(redir_valid), 1);
      #2;
      rst = 1'b1;
      redir_ready = 1'b1;
      #1;
      check("midrst_rv", 32'(redir_valid), 0);
      check("midrst_flush", 32'(flush), 0);
      check("midrst_pc", redir_pc, 0);
      check("midrst_rdy", 32'(in_ready), 1);
      check("midrst_tk", 32'(taken_cnt), 0);
      check("midrst_res", 32'(resolve_cnt), 0);
      @(negedge clk);
      rst = 1'b0;
      redir_ready = 1'b0;
      m_tk = '0;
      m_res = '0;
      for (int n = 0; n < 255; n++) run(4'd15, $urandom, $urandom, $urandom, 0, 0);
      check("wrap_pre", 32'(taken_cnt), 32'hFF);
      run(4'd15, 32'd1, 32'd2, 32'h500, 0, 0);
      check("wrap_tk", 32'(taken_cnt), 0);
      check("wrap_res", 32'(resolve_cnt), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
